decode_issue_stage: RTL and testbench

- Decode stage directly upstream of the execute ALU. Accepts one fetched RV32I instruction per handshake.
- Reads rs1/rs2 through a combinational register-file read port and decodes OP, OP-IMM, LUI and AUIPC.
- Registers ALU operands a/b, the 5-bit ALU control code, and writeback info into an ID/EX pipeline register with valid/ready backpressure and flush.

---
 rtl/rv32_pkg.sv | 49 ++++
 rtl/rv32_alu_decoder.sv | 100 ++++++++++
 rtl/decode_issue_stage.sv | 97 +++++++++
 tb/tb_decode_issue_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I decode constants: opcodes, funct fields and ALU control codes.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'b00000,
    ALU_SUB   = 5'b00001,
    ALU_SLL   = 5'b00010,
    ALU_SLT   = 5'b00011,
    ALU_SLTU  = 5'b00100,
    ALU_XOR   = 5'b00101,
    ALU_SRL   = 5'b00110,
    ALU_SRA   = 5'b00111,
    ALU_OR    = 5'b01000,
    ALU_AND   = 5'b01001,
    ALU_ADDI  = 5'b01010,
    ALU_SLTI  = 5'b01011,
    ALU_SLTIU = 5'b01100,
    ALU_XORI  = 5'b01101,
    ALU_ORI   = 5'b01110,
    ALU_ANDI  = 5'b01111,
    ALU_SLLI  = 5'b10001,
    ALU_SRLI  = 5'b10010,
    ALU_SRAI  = 5'b10011
  } alu_ctr_e;

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/rv32_alu_decoder.sv
// Combinational RV32I decode of OP, OP-IMM, LUI and AUIPC into ALU operands and control.
module rv32_alu_decoder
  import rv32_pkg::*;
(
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [4:0]      ctr,
  output logic            wb_en,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       bad;
  alu_ctr_e   code;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    a    = '0;
    b    = '0;
    code = ALU_ADD;
    bad  = 1'b1;
    unique case (opcode)
      OPC_OP: begin
        bad = 1'b0;
        a   = rs1_data;
        b   = rs2_data;
        unique case (funct3)
          F3_ADD:  if (funct7 == F7_BASE) code = ALU_ADD;
                   else if (funct7 == F7_ALT) code = ALU_SUB;
                   else bad = 1'b1;
          F3_SR:   if (funct7 == F7_BASE) code = ALU_SRL;
                   else if (funct7 == F7_ALT) code = ALU_SRA;
                   else bad = 1'b1;
          F3_SLL:  begin code = ALU_SLL;  bad = (funct7 != F7_BASE); end
          F3_SLT:  begin code = ALU_SLT;  bad = (funct7 != F7_BASE); end
          F3_SLTU: begin code = ALU_SLTU; bad = (funct7 != F7_BASE); end
          F3_XOR:  begin code = ALU_XOR;  bad = (funct7 != F7_BASE); end
          F3_OR:   begin code = ALU_OR;   bad = (funct7 != F7_BASE); end
          F3_AND:  begin code = ALU_AND;  bad = (funct7 != F7_BASE); end
          default: bad = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        bad = 1'b0;
        a   = rs1_data;
        b   = sext12(instr[31:20]);
        unique case (funct3)
          F3_ADD:  code = ALU_ADDI;
          F3_SLT:  code = ALU_SLTI;
          F3_SLTU: code = ALU_SLTIU;
          F3_XOR:  code = ALU_XORI;
          F3_OR:   code = ALU_ORI;
          F3_AND:  code = ALU_ANDI;
          F3_SLL: begin
            b    = {{(XLEN-5){1'b0}}, instr[24:20]};
            code = ALU_SLLI;
            bad  = (funct7 != F7_BASE);
          end
          F3_SR: begin
            b = {{(XLEN-5){1'b0}}, instr[24:20]};
            if (funct7 == F7_BASE) code = ALU_SRLI;
            else if (funct7 == F7_ALT) code = ALU_SRAI;
            else bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      OPC_LUI: begin
        bad = 1'b0;
        b   = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        bad = 1'b0;
        a   = pc;
        b   = {instr[31:12], 12'b0};
      end
      default: bad = 1'b1;
    endcase
    // Illegal encodings hand off zeroed operands regardless of which branch flagged them.
    if (bad) begin
      a    = '0;
      b    = '0;
      code = ALU_ADD;
    end
  end

  assign ctr     = code;
  assign illegal = bad;
  assign wb_en   = !bad && (instr[11:7] != 5'd0);

endmodule

// File: rtl/decode_issue_stage.sv
// Decode stage: regfile read addressing, RV32I decode and ID/EX register with valid/ready and flush.
module decode_issue_stage
  import rv32_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [4:0]      out_alu_ctr,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e          state, state_nxt;
  logic            load;
  logic [XLEN-1:0] dec_a, dec_b;
  logic [4:0]      dec_ctr;
  logic            dec_wb_en, dec_illegal;

  assign rs1_addr  = in_instr[19:15];
  assign rs2_addr  = in_instr[24:20];
  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign load      = in_valid && in_ready && !flush;

  rv32_alu_decoder u_dec (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .a        (dec_a),
    .b        (dec_b),
    .ctr      (dec_ctr),
    .wb_en    (dec_wb_en),
    .illegal  (dec_illegal)
  );

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (load) state_nxt = FULL;
        FULL:  if (out_ready && !load) state_nxt = EMPTY;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a       <= '0;
      out_b       <= '0;
      out_alu_ctr <= '0;
      out_rd      <= '0;
      out_wb_en   <= 1'b0;
      out_illegal <= 1'b0;
      out_pc      <= RESET_PC;
    end else if (load) begin
      out_a       <= dec_a;
      out_b       <= dec_b;
      out_alu_ctr <= dec_ctr;
      out_rd      <= in_instr[11:7];
      out_wb_en   <= dec_wb_en;
      out_illegal <= dec_illegal;
      out_pc      <= in_pc;
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed self-checking bench for decode_issue_stage.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_a, out_b, out_pc;
  logic [4:0]  out_alu_ctr, out_rd;
  logic        out_wb_en, out_illegal;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  decode_issue_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_alu_ctr (out_alu_ctr),
    .out_rd      (out_rd),
    .out_wb_en   (out_wb_en),
    .out_illegal (out_illegal),
    .out_pc      (out_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction with out_ready=1 and capture it on the next edge.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    in_instr  = instr;
    in_pc     = pc;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] ctr, input logic [4:0] rd,
                            input logic wb, input logic ill);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".a"}, out_a, a);
    check({tag, ".b"}, out_b, b);
    check({tag, ".ctr"}, 32'(out_alu_ctr), 32'(ctr));
    check({tag, ".rd"}, 32'(out_rd), 32'(rd));
    check({tag, ".wb"}, 32'(out_wb_en), 32'(wb));
    check({tag, ".ill"}, 32'(out_illegal), 32'(ill));
  endtask

  initial begin
    rs1_data = 32'd5;
    rs2_data = 32'd7;
    #12;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.pc", out_pc, 32'h0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    in_instr = 32'h002081B3;
    #1;
    check("rs1_addr", 32'(rs1_addr), 32'd1);
    check("rs2_addr", 32'(rs2_addr), 32'd2);
    issue(32'h002081B3, 32'h40);
    expect_out("add", 32'd5, 32'd7, 5'b00000, 5'd3, 1'b1, 1'b0);
    check("add.pc", out_pc, 32'h40);

    issue(32'h40208533, 32'h44);
    expect_out("sub", 32'd5, 32'd7, 5'b00001, 5'd10, 1'b1, 1'b0);
    issue(32'hFFF08213, 32'h48);
    expect_out("addi", 32'd5, 32'hFFFF_FFFF, 5'b01010, 5'd4, 1'b1, 1'b0);
    issue(32'h41F0D293, 32'h4C);
    expect_out("srai", 32'd5, 32'd31, 5'b10011, 5'd5, 1'b1, 1'b0);
    issue(32'hABCDE337, 32'h50);
    expect_out("lui", 32'd0, 32'hABCD_E000, 5'b00000, 5'd6, 1'b1, 1'b0);
    issue(32'h12345397, 32'h100);
    expect_out("auipc", 32'h100, 32'h1234_5000, 5'b00000, 5'd7, 1'b1, 1'b0);
    issue(32'h0000A403, 32'h104);
    expect_out("load", 32'd0, 32'd0, 5'b00000, 5'd8, 1'b0, 1'b1);
    issue(32'h022084B3, 32'h108);
    expect_out("mul", 32'd0, 32'd0, 5'b00000, 5'd9, 1'b0, 1'b1);
    issue(32'h00208033, 32'h10C);
    expect_out("add_x0", 32'd5, 32'd7, 5'b00000, 5'd0, 1'b0, 1'b0);
    issue(32'h002081B0, 32'h110);
    expect_out("lowbits", 32'd0, 32'd0, 5'b00000, 5'd3, 1'b0, 1'b1);

    // Drains to empty with no new input.
    tick();
    check("drain.valid", 32'(out_valid), 32'd0);

    // Backpressure: add held for 3 cycles while sub waits upstream.
    issue(32'h002081B3, 32'h200);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h40208533;
    in_pc     = 32'h204;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp.in_ready", 32'(in_ready), 32'd0);
      tick();
      check("bp.valid", 32'(out_valid), 32'd1);
      check("bp.ctr", 32'(out_alu_ctr), 32'b00000);
      check("bp.rd", 32'(out_rd), 32'd3);
      check("bp.pc", out_pc, 32'h200);
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(in_ready), 32'd1);
    tick();
    expect_out("bp.sub", 32'd5, 32'd7, 5'b00001, 5'd10, 1'b1, 1'b0);
    check("bp.sub_pc", out_pc, 32'h204);

    // Flush while full with a valid incoming instruction.
    in_instr = 32'hABCDE337;
    in_pc    = 32'h208;
    in_valid = 1'b1;
    flush    = 1'b1;
    out_ready = 1'b0;
    tick();
    check("flush.valid", 32'(out_valid), 32'd0);
    check("flush.in_ready", 32'(in_ready), 32'd1);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("flush.not_captured", 32'(out_valid), 32'd0);

    // Asynchronous reset while holding an instruction.
    issue(32'h12345397, 32'h300);
    check("prerst.valid", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(out_valid), 32'd0);
    check("arst.a", out_a, 32'd0);
    check("arst.b", out_b, 32'd0);
    check("arst.ctr", 32'(out_alu_ctr), 32'd0);
    check("arst.rd", 32'(out_rd), 32'd0);
    check("arst.wb", 32'(out_wb_en), 32'd0);
    check("arst.ill", 32'(out_illegal), 32'd0);
    check("arst.pc", out_pc, 32'h0);
    check("arst.in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
